// File: rtl/date_pkg.sv
// date_pkg: shared types and constants for the date -> day-of-year converter.
//   state_t      : converter FSM states
//   DAYS_MAX     : largest day-of-year value (leap year)
//   MONTHS       : number of months in a year
//   LEN_*        : month lengths in days
package date_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ACCUM,
    S_HUND,
    S_TENS,
    S_DONE
  } state_t;

  localparam int DAYS_MAX = 366;
  localparam int MONTHS   = 12;

  localparam logic [4:0] LEN_LONG     = 5'd31;
  localparam logic [4:0] LEN_SHORT    = 5'd30;
  localparam logic [4:0] LEN_FEB      = 5'd28;
  localparam logic [4:0] LEN_FEB_LEAP = 5'd29;

endpackage

// File: rtl/date_to_daynum_month_len.sv
// month_len: combinational month length lookup.
//   month : month number, 1..12 (anything else yields 0)
//   leap  : February has 29 days when set
//   len   : number of days in the month
module month_len
  import date_pkg::*;
(
  input  logic [3:0] month,
  input  logic       leap,
  output logic [4:0] len
);

  always_comb begin
    len = '0;
    case (month)
      4'd2:                                len = leap ? LEN_FEB_LEAP : LEN_FEB;
      4'd4, 4'd6, 4'd9, 4'd11:             len = LEN_SHORT;
      4'd1, 4'd3, 4'd5, 4'd7, 4'd8, 4'd10,
      4'd12:                               len = LEN_LONG;
      default:                             len = '0;
    endcase
  end

endmodule

// File: rtl/date_to_daynum.sv
// date_to_daynum: converts month (binary) + BCD day into day-of-year.
//   clk, reset       : clock, synchronous active-high reset
//   start            : request pulse, accepted only while idle
//   month/day1/day0  : date to convert (binary month, BCD day digits)
//   leap             : February has 29 days
//   busy             : request in progress (through the done cycle)
//   done             : one-cycle completion pulse
//   err              : date was invalid, results forced to zero
//   day_num          : binary day-of-year
//   hund/tens/ones   : BCD digits of day_num
// Month lengths are summed one per cycle, then the sum is split into BCD
// digits by repeated subtraction of 100 and 10.
module date_to_daynum
  import date_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] month,
  input  logic [3:0] day1,
  input  logic [3:0] day0,
  input  logic       leap,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [8:0] day_num,
  output logic [3:0] hund,
  output logic [3:0] tens,
  output logic [3:0] ones
);

  state_t     state, state_d;

  // captured request
  logic [3:0] mon_q, d1_q, d0_q;
  logic       leap_q;
  logic       cap;

  // working registers
  logic [8:0] acc, acc_d;
  logic [3:0] idx, idx_d;
  logic [3:0] h_q, h_d, t_q, t_d;

  // output next values
  logic       err_d;
  logic [8:0] day_num_d;
  logic [3:0] hund_d, tens_d, ones_d;

  // shared length lookup: captured month while checking, running index
  // while accumulating
  logic [3:0] len_month;
  logic [4:0] len;

  month_len u_month_len (
    .month (len_month),
    .leap  (leap_q),
    .len   (len)
  );

  logic [7:0] dval;
  logic       invalid;

  assign dval    = ({4'd0, d1_q} * 8'd10) + {4'd0, d0_q};
  // len is 0 for an out-of-range month, so dval > len also covers it
  assign invalid = (mon_q == 4'd0) || (mon_q > 4'(MONTHS)) ||
                   (d1_q > 4'd3) || (d0_q > 4'd9) ||
                   (dval == 8'd0) || (dval > {3'd0, len});

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  always_comb begin
    state_d   = state;
    cap       = 1'b0;
    acc_d     = acc;
    idx_d     = idx;
    h_d       = h_q;
    t_d       = t_q;
    len_month = mon_q;
    err_d     = err;
    day_num_d = day_num;
    hund_d    = hund;
    tens_d    = tens;
    ones_d    = ones;

    case (state)
      S_IDLE: begin
        if (start) begin
          cap     = 1'b1;
          state_d = S_CHECK;
        end
      end

      S_CHECK: begin
        if (invalid) begin
          err_d     = 1'b1;
          day_num_d = '0;
          hund_d    = '0;
          tens_d    = '0;
          ones_d    = '0;
          state_d   = S_DONE;
        end else begin
          acc_d = {1'b0, dval};
          idx_d = 4'd1;
          h_d   = '0;
          t_d   = '0;
          if (mon_q > 4'd1) begin
            state_d = S_ACCUM;
          end else begin
            // January: the day itself is the result
            day_num_d = {1'b0, dval};
            state_d   = S_HUND;
          end
        end
      end

      S_ACCUM: begin
        len_month = idx;
        acc_d     = acc + {4'd0, len};
        idx_d     = idx + 4'd1;
        // add the last full month before the target, then split digits
        if (idx == (mon_q - 4'd1)) begin
          day_num_d = acc + {4'd0, len};
          state_d   = S_HUND;
        end
      end

      S_HUND: begin
        if (acc >= 9'd100) begin
          acc_d = acc - 9'd100;
          h_d   = h_q + 4'd1;
        end else begin
          state_d = S_TENS;
        end
      end

      S_TENS: begin
        if (acc >= 9'd10) begin
          acc_d = acc - 9'd10;
          t_d   = t_q + 4'd1;
        end else begin
          hund_d  = h_q;
          tens_d  = t_q;
          ones_d  = acc[3:0];
          err_d   = 1'b0;
          state_d = S_DONE;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      mon_q   <= '0;
      d1_q    <= '0;
      d0_q    <= '0;
      leap_q  <= 1'b0;
      acc     <= '0;
      idx     <= '0;
      h_q     <= '0;
      t_q     <= '0;
      err     <= 1'b0;
      day_num <= '0;
      hund    <= '0;
      tens    <= '0;
      ones    <= '0;
    end else begin
      state   <= state_d;
      acc     <= acc_d;
      idx     <= idx_d;
      h_q     <= h_d;
      t_q     <= t_d;
      err     <= err_d;
      day_num <= day_num_d;
      hund    <= hund_d;
      tens    <= tens_d;
      ones    <= ones_d;
      if (cap) begin
        mon_q  <= month;
        d1_q   <= day1;
        d0_q   <= day0;
        leap_q <= leap;
      end
    end
  end

endmodule

// File: tb/tb_date_to_daynum.sv
// Scoreboard bench for date_to_daynum: requests push a model result,
// a monitor pops and compares on every done pulse.
module tb_date_to_daynum;

  logic       clk = 1'b0;
  logic       reset, start, leap;
  logic [3:0] month, day1, day0;
  logic       busy, done, err;
  logic [8:0] day_num;
  logic [3:0] hund, tens, ones;

  date_to_daynum dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .month   (month),
    .day1    (day1),
    .day0    (day0),
    .leap    (leap),
    .busy    (busy),
    .done    (done),
    .err     (err),
    .day_num (day_num),
    .hund    (hund),
    .tens    (tens),
    .ones    (ones)
  );

  always #5 clk = ~clk;

  typedef struct {
    int dn; int h; int t; int o; int err; int lat; int acc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int cyc = 0;
  int n_chk = 0, n_pass = 0;
  int n_done = 0, n_issued = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Reference: day-of-year from a month-length table and plain arithmetic.
  function automatic exp_t model(int m, int d1, int d0, int lp);
    int ml[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    exp_t r;
    int d, doy;
    r = '{default: 0};
    if (lp != 0) ml[1] = 29;
    d = d1 * 10 + d0;
    if (m < 1 || m > 12 || d1 > 3 || d0 > 9 || d < 1 || d > ml[m-1]) begin
      r.err = 1;
      r.lat = 1;
      return r;
    end
    doy = d;
    for (int i = 0; i < m - 1; i++) doy += ml[i];
    r.dn  = doy;
    r.h   = doy / 100;
    r.t   = (doy / 10) % 10;
    r.o   = doy % 10;
    r.lat = m + r.h + r.t + 2;
    return r;
  endfunction

  // monitor
  always @(posedge clk) begin
    #1;
    if (done) begin
      n_done++;
      if (sb.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got done=1 expected no pending request (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("day_num", int'(day_num), mon_e.dn);
        chk("hund",    int'(hund),    mon_e.h);
        chk("tens",    int'(tens),    mon_e.t);
        chk("ones",    int'(ones),    mon_e.o);
        chk("err",     int'(err),     mon_e.err);
        chk("latency", cyc - mon_e.acc, mon_e.lat);
      end
    end
  end

  task automatic wait_idle();
    int w = 0;
    while (busy && w < 200) begin
      @(negedge clk);
      w++;
    end
    if (busy) begin
      n_chk++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 200 cycles");
    end
  endtask

  // Drive one request on the next idle cycle. With hold, start stays high
  // so the next call is accepted back to back.
  task automatic issue(int m, int d1, int d0, int lp, int hold);
    exp_t e;
    @(negedge clk);
    wait_idle();
    month = 4'(m);
    day1  = 4'(d1);
    day0  = 4'(d0);
    leap  = 1'(lp);
    start = 1'b1;
    e     = model(m, d1, d0, lp);
    e.acc = cyc + 1;
    sb.push_back(e);
    n_issued++;
    @(negedge clk);
    if (hold == 0) start = 1'b0;
    // scramble captured inputs; result must not change
    month = 4'($urandom);
    day1  = 4'($urandom);
    day0  = 4'($urandom);
    leap  = 1'($urandom);
  endtask

  initial begin
    int m, d1, d0, lp;
    reset = 1'b1; start = 1'b0; month = '0; day1 = '0; day0 = '0; leap = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy",    int'(busy),    0);
    chk("rst_done",    int'(done),    0);
    chk("rst_err",     int'(err),     0);
    chk("rst_day_num", int'(day_num), 0);
    chk("rst_digits",  int'({hund, tens, ones}), 0);
    reset = 1'b0;

    // directed dates
    issue(3, 0, 1, 0, 0);    // 60
    issue(3, 0, 1, 1, 0);    // 61
    issue(12, 3, 1, 1, 0);   // 366
    issue(1, 0, 1, 0, 0);    // 1
    issue(12, 3, 1, 0, 0);   // 365
    issue(2, 2, 9, 0, 0);    // Feb 29 non-leap: err
    issue(2, 2, 9, 1, 0);    // Feb 29 leap: 60
    issue(13, 0, 1, 0, 0);
    issue(0, 0, 1, 0, 0);
    issue(5, 4, 0, 0, 0);
    issue(5, 0, 10, 0, 0);
    issue(5, 0, 0, 0, 0);
    issue(4, 3, 1, 0, 0);    // Apr 31: err
    issue(4, 3, 0, 0, 0);

    // extra starts while busy are ignored
    issue(7, 1, 5, 0, 0);
    for (int w = 0; w < 100; w++) begin
      @(negedge clk);
      if (!busy) break;
      start = 1'b1;
      month = 4'($urandom_range(1, 12));
      day1  = 4'($urandom_range(0, 2));
      day0  = 4'($urandom_range(1, 9));
    end
    start = 1'b0;

    // reset during ACCUM: no done, outputs cleared
    issue(12, 3, 1, 1, 0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sb.delete();
    n_issued--;
    chk("mid_rst_busy",    int'(busy),    0);
    chk("mid_rst_done",    int'(done),    0);
    chk("mid_rst_day_num", int'(day_num), 0);
    chk("mid_rst_digits",  int'({hund, tens, ones}), 0);
    chk("mid_rst_err",     int'(err),     0);
    repeat (30) @(negedge clk);
    issue(8, 1, 9, 0, 0);

    // back-to-back with start held high
    for (int k = 0; k < 6; k++)
      issue($urandom_range(1, 12), $urandom_range(0, 2), $urandom_range(1, 9),
            $urandom_range(0, 1), 1);
    @(negedge clk);
    wait_idle();
    start = 1'b0;

    // random mix, mostly valid dates
    for (int k = 0; k < 150; k++) begin
      m  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(1, 12);
      d1 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
      d0 = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 9);
      lp = $urandom_range(0, 1);
      issue(m, d1, d0, lp, 0);
    end

    @(negedge clk);
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb.size(), 0);
    chk("done_count", n_done, n_issued);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
